// File: rtl/lector_contadores_if.sv
`default_nettype none
// ============================================================================
// Module   : lector_contadores_if
// Purpose  : Read request / data return handshake towards the counter block.
// Revision : 1.0 - initial release
// ============================================================================
interface lector_contadores_if;
    logic       req;
    logic [2:0] idx;
    logic [4:0] data;
    logic       valid;

    modport master (output req, output idx, input data, input valid);
    modport slave  (input req, input idx, output data, output valid);
endinterface
`default_nettype wire

// File: rtl/lector_contadores.sv
`default_nettype none
// ============================================================================
// Module   : lector_contadores
// Purpose  : Sequentially reads five counters over a req/valid handshake,
//            with a per-read timeout that loads zero and raises a sticky err.
// Revision : 1.0 - initial release
// ============================================================================
module lector_contadores (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    lector_contadores_if.master         bus,
    output logic [4:0]                  cnt0,
    output logic [4:0]                  cnt1,
    output logic [4:0]                  cnt2,
    output logic [4:0]                  cnt3,
    output logic [4:0]                  cnt4,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam logic [2:0] LAST_IDX    = 3'd4;
    localparam logic [2:0] TIMEOUT_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             req_q, req_n;
    logic [2:0]       idx_q, idx_n;
    logic [2:0]       tmo_q, tmo_n;
    logic [4:0][4:0]  cnt_q, cnt_n;
    logic             busy_n, done_n, err_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= 1'b0;
            idx_q <= 3'd0;
            tmo_q <= 3'd0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            req_q <= req_n;
            idx_q <= idx_n;
            tmo_q <= tmo_n;
            cnt_q <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        tmo_n   = tmo_q;
        cnt_n   = cnt_q;
        err_n   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = REQ;
                    idx_n   = 3'd0;
                    tmo_n   = 3'd0;
                    err_n   = 1'b0;
                end
            end
            REQ: begin
                // A timed-out read behaves like a capture of zero, plus err.
                if (bus.valid || (tmo_q == TIMEOUT_MAX)) begin
                    cnt_n[idx_q] = bus.valid ? bus.data : 5'd0;
                    if (!bus.valid) begin
                        err_n = 1'b1;
                    end
                    state_n = (idx_q < LAST_IDX) ? GAP : DONE;
                end else begin
                    tmo_n = tmo_q + 3'd1;
                end
            end
            GAP: begin
                state_n = REQ;
                idx_n   = idx_q + 3'd1;
                tmo_n   = 3'd0;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        req_n  = (state_n == REQ);
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    assign bus.req = req_q;
    assign bus.idx = idx_q;
    assign cnt0    = cnt_q[0];
    assign cnt1    = cnt_q[1];
    assign cnt2    = cnt_q[2];
    assign cnt3    = cnt_q[3];
    assign cnt4    = cnt_q[4];

endmodule
`default_nettype wire

// File: tb/tb_lector_contadores.sv
`default_nettype none
// ============================================================================
// Module   : tb_lector_contadores
// Purpose  : Directed self-checking bench for the five-counter reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lector_contadores;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] cnt0, cnt1, cnt2, cnt3, cnt4;
    logic       busy, done, err;

    lector_contadores_if bus();

    lector_contadores dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus.master),
        .cnt0  (cnt0),
        .cnt1  (cnt1),
        .cnt2  (cnt2),
        .cnt3  (cnt3),
        .cnt4  (cnt4),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    int total = 0;
    int bad   = 0;

    // Counter-block model: answers after resp_delay REQ cycles, never for drop_idx.
    logic [4:0] tbl [5];
    int         resp_delay = 0;
    logic       resp_en    = 1'b0;
    int         drop_idx   = -1;
    logic       stray      = 1'b0;
    int         req_age    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) req_age <= bus.req ? req_age + 1 : 0;

    assign bus.valid = stray | (resp_en && bus.req && (req_age >= resp_delay)
                                && (int'(bus.idx) != drop_idx));
    assign bus.data  = stray ? 5'd21 : tbl[bus.idx];

    logic [2:0] idx_log [$];
    logic       req_prev   = 1'b0;
    int         done_count = 0;
    int         req2_cycles = 0;

    always @(negedge clk) begin
        if (done) done_count++;
        if (bus.req && (bus.idx == 3'd2)) req2_cycles++;
        if (bus.req && !req_prev) idx_log.push_back(bus.idx);
        req_prev = bus.req;
    end

    wire [24:0] cnt_all = {cnt0, cnt1, cnt2, cnt3, cnt4};

    task automatic set_tbl(input logic [4:0] a, b, c, d, e);
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d; tbl[4] = e;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns extra negedges from cycle 1 until done is seen high.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 200 && !done) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        logic [24:0] exp;
        #1;
        total++;
        if ({bus.req, bus.idx, busy, done, err, cnt_all} !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {bus.req, bus.idx, busy, done, err, cnt_all});
        end
        start = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ignores_start: busy=%b want 0", busy);
        end
        set_tbl(5'd1, 5'd2, 5'd3, 5'd4, 5'd5);
        resp_en = 1'b1;
        resp_delay = 0;
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({busy, bus.req, bus.idx} !== 5'b11000) begin
            bad++;
            $display("FAIL first_start_after_reset: got %b want 11000", {busy, bus.req, bus.idx});
        end
        repeat (12) @(negedge clk);
        exp = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        total++;
        if (cnt_all !== exp) begin
            bad++;
            $display("FAIL post_reset_readout: got %h want %h", cnt_all, exp);
        end
    endtask

    task automatic test_scen_a;
        int c;
        logic [24:0] exp;
        set_tbl(5'd3, 5'd0, 5'd7, 5'd31, 5'd1);
        resp_delay = 1;
        idx_log.delete();
        done_count = 0;
        pulse_start;
        wait_done(c);
        repeat (3) @(negedge clk);
        exp = {5'd3, 5'd0, 5'd7, 5'd31, 5'd1};
        total++;
        if (c !== 14) begin
            bad++;
            $display("FAIL a_latency: done at cycle %0d want 15", c + 1);
        end
        total++;
        if (cnt_all !== exp || err !== 1'b0) begin
            bad++;
            $display("FAIL a_counts: got %h err=%b want %h err=0", cnt_all, err, exp);
        end
        total++;
        if (done_count !== 1) begin
            bad++;
            $display("FAIL a_done_pulses: got %0d want 1", done_count);
        end
        total++;
        if (idx_log.size() != 5 || idx_log[0] !== 3'd0 || idx_log[1] !== 3'd1 ||
            idx_log[2] !== 3'd2 || idx_log[3] !== 3'd3 || idx_log[4] !== 3'd4) begin
            bad++;
            $display("FAIL a_idx_seq: got %p want 0,1,2,3,4", idx_log);
        end
        total++;
        if (bus.idx !== 3'd4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL a_idle_hold: idx=%0d busy=%b want idx=4 busy=0", bus.idx, busy);
        end
    endtask

    task automatic test_scen_b;
        int first_done = 0;
        int gapbad = 0;
        logic [24:0] exp;
        set_tbl(5'd31, 5'd16, 5'd5, 5'd10, 5'd27);
        resp_delay = 0;
        pulse_start;
        for (int k = 1; k <= 12; k++) begin
            if (done && first_done == 0) first_done = k;
            if (k <= 9 && bus.req !== ((k % 2) == 1)) gapbad++;
            @(negedge clk);
        end
        exp = {5'd31, 5'd16, 5'd5, 5'd10, 5'd27};
        total++;
        if (first_done !== 10) begin
            bad++;
            $display("FAIL b_latency: done at cycle %0d want 10", first_done);
        end
        total++;
        if (gapbad !== 0) begin
            bad++;
            $display("FAIL b_gap_pattern: got %0d bad req cycles want 0", gapbad);
        end
        total++;
        if (cnt_all !== exp || err !== 1'b0) begin
            bad++;
            $display("FAIL b_counts: got %h err=%b want %h err=0", cnt_all, err, exp);
        end
    endtask

    task automatic test_scen_c;
        int c;
        set_tbl(5'd2, 5'd4, 5'd6, 5'd8, 5'd10);
        resp_delay = 0;
        drop_idx = 2;
        req2_cycles = 0;
        pulse_start;
        wait_done(c);
        repeat (2) @(negedge clk);
        total++;
        if (c !== 16) begin
            bad++;
            $display("FAIL c_latency: done at cycle %0d want 17", c + 1);
        end
        total++;
        if (req2_cycles !== 8) begin
            bad++;
            $display("FAIL c_timeout_len: got %0d REQ cycles want 8", req2_cycles);
        end
        total++;
        if (cnt_all !== {5'd2, 5'd4, 5'd0, 5'd8, 5'd10} || err !== 1'b1) begin
            bad++;
            $display("FAIL c_timeout_result: got %h err=%b want %h err=1", cnt_all, err,
                     {5'd2, 5'd4, 5'd0, 5'd8, 5'd10});
        end
        drop_idx = -1;
        repeat (5) @(negedge clk);
        total++;
        if (err !== 1'b1 || cnt2 !== 5'd0) begin
            bad++;
            $display("FAIL c_err_sticky: err=%b cnt2=%0d want err=1 cnt2=0", err, cnt2);
        end
    endtask

    task automatic test_scen_d;
        int guard = 0;
        set_tbl(5'd9, 5'd18, 5'd27, 5'd1, 5'd2);
        resp_delay = 0;
        done_count = 0;
        pulse_start;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL d_err_clear: err=%b want 0", err);
        end
        // Hold start high for every busy cycle, DONE included.
        while (busy && guard < 40) begin
            start = 1'b1;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (done_count !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL d_single_done: dones=%0d busy=%b want 1 and 0", done_count, busy);
        end
        total++;
        if (cnt_all !== {5'd9, 5'd18, 5'd27, 5'd1, 5'd2}) begin
            bad++;
            $display("FAIL d_counts: got %h want %h", cnt_all, {5'd9, 5'd18, 5'd27, 5'd1, 5'd2});
        end
    endtask

    task automatic test_scen_e;
        int guard = 0;
        int c;
        set_tbl(5'd11, 5'd12, 5'd13, 5'd14, 5'd15);
        resp_delay = 1;
        pulse_start;
        while (!(bus.req && bus.idx == 3'd3) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 40) begin
            bad++;
            $display("FAIL e_reach_idx3: idx=%0d want 3", bus.idx);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.req, bus.idx, busy, done, err, cnt_all} !== 32'd0) begin
            bad++;
            $display("FAIL e_async_reset: got %h want 0", {bus.req, bus.idx, busy, done, err, cnt_all});
        end
        @(negedge clk);
        reset = 1'b0;
        set_tbl(5'd20, 5'd21, 5'd22, 5'd23, 5'd24);
        pulse_start;
        total++;
        if ({busy, bus.req, bus.idx} !== 5'b11000) begin
            bad++;
            $display("FAIL e_restart_idx0: got %b want 11000", {busy, bus.req, bus.idx});
        end
        wait_done(c);
        repeat (3) @(negedge clk);
        total++;
        if (cnt_all !== {5'd20, 5'd21, 5'd22, 5'd23, 5'd24}) begin
            bad++;
            $display("FAIL e_counts: got %h want %h", cnt_all, {5'd20, 5'd21, 5'd22, 5'd23, 5'd24});
        end
    endtask

    task automatic test_scen_f;
        int guard = 0;
        logic [24:0] snap;
        snap = cnt_all;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        total++;
        if (cnt_all !== snap || bus.idx !== 3'd4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL f_idle_stray: cnt=%h idx=%0d busy=%b want %h 4 0", cnt_all, bus.idx, busy, snap);
        end
        set_tbl(5'd30, 5'd29, 5'd28, 5'd27, 5'd26);
        resp_delay = 0;
        idx_log.delete();
        done_count = 0;
        pulse_start;
        while (busy && guard < 40) begin
            stray = busy && !bus.req && !done;
            @(negedge clk);
            guard++;
        end
        stray = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (cnt_all !== {5'd30, 5'd29, 5'd28, 5'd27, 5'd26}) begin
            bad++;
            $display("FAIL f_gap_stray: got %h want %h", cnt_all, {5'd30, 5'd29, 5'd28, 5'd27, 5'd26});
        end
        total++;
        if (idx_log.size() != 5 || idx_log[4] !== 3'd4 || done_count !== 1) begin
            bad++;
            $display("FAIL f_idx_seq: got %p dones=%0d want 0..4 and 1", idx_log, done_count);
        end
    endtask

    initial begin
        test_reset;
        test_scen_a;
        test_scen_b;
        test_scen_c;
        test_scen_d;
        test_scen_e;
        test_scen_f;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
